// File: rtl/dsp_audio_pkg.sv
// Shared definitions for the DSP audio path (I2S playback and capture).
//   I2S_FMT_I2S  : level driven on the DAC format pin for standard I2S framing
//   DEF_*        : default sample width, slot width and BCLK divider
//   FRAME_BITS   : BCLK periods per stereo frame at the default slot width
//   tx_state_t   : transmitter sequencing states
package dsp_audio_pkg;

    localparam logic I2S_FMT_I2S  = 1'b0;

    localparam int   DEF_DATA_W   = 24;
    localparam int   DEF_SLOT_W   = 32;
    localparam int   DEF_BCLK_DIV = 8;
    localparam int   FRAME_BITS   = 2 * DEF_SLOT_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/i2s_clk_div.sv
// I2S master clock generator: divides clk into BCLK and derives LRCK from a
// per-frame bit counter. Also usable as the clock source for a slave-mode ADC.
//   clk, rst          : system clock, synchronous active-high reset
//   run               : counters advance while 1, held at 0 otherwise
//   run_nxt           : value of run on the next clk (qualifies look-ahead strobes)
//   bclk, lrck        : registered bit clock and word select
//   frame_start       : current clk is div_cnt=0, bit_cnt=0 while running
//   frame_end         : current clk is the last clk of the frame while running
//   frame_start_nxt   : next clk is a frame start
//   fall_tick_nxt     : next clk is div_cnt=0 (BCLK falling edge) while running
//   bit_cnt_nxt       : bit counter value for the next clk
module i2s_clk_div
    import dsp_audio_pkg::*;
#(
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          run_nxt,
    output logic                          bclk,
    output logic                          lrck,
    output logic                          frame_start,
    output logic                          frame_end,
    output logic                          frame_start_nxt,
    output logic                          fall_tick_nxt,
    output logic [$clog2(2*SLOT_W)-1:0]   bit_cnt_nxt
);

    localparam int FRAME = 2 * SLOT_W;
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(FRAME);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
    localparam logic [BIT_W-1:0] R_START  = BIT_W'(SLOT_W);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [BIT_W-1:0] bit_nxt;

    always_comb begin
        div_nxt = '0;
        bit_nxt = '0;
        if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
                bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end else begin
                div_nxt = div_cnt + 1'b1;
                bit_nxt = bit_cnt;
            end
        end
    end

    // bclk/lrck are registered from the next counter values so that they
    // line up with div_cnt/bit_cnt in the same clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            bclk    <= (div_nxt >= DIV_HALF);
            lrck    <= (bit_nxt >= R_START);
        end
    end

    assign frame_start     = run && (div_cnt == '0) && (bit_cnt == '0);
    assign frame_end       = run && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);
    assign frame_start_nxt = run_nxt && (div_nxt == '0) && (bit_nxt == '0);
    assign fall_tick_nxt   = run_nxt && (div_nxt == '0);
    assign bit_cnt_nxt     = bit_nxt;

endmodule

// File: rtl/dac_i2s_tx.sv
// I2S master transmitter for the stereo audio DAC. Accepts 24-bit PCM pairs
// over valid/ready into a one-entry holding register and serialises them
// MSB-first on sdata with the standard one-BCLK delay after each LRCK edge.
//   clk, rst          : system clock, synchronous active-high reset
//   enable            : run frames; on deassertion the current frame completes
//   s_left, s_right   : PCM sample pair, two's complement
//   s_valid, s_ready  : upstream handshake, s_ready = holding register empty
//   bclk, lrck, sdata : I2S pins to the DAC (sdata changes on BCLK fall)
//   underrun          : 1-clk pulse when a frame starts with no pair held
//   fmt               : DAC format select, fixed to I2S
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | counters and pins parked at 0, waiting for enable
// ST_RUN  | frames running; leaves only at frame end with enable low
module dac_i2s_tx
    import dsp_audio_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bclk,
    output logic              lrck,
    output logic              sdata,
    output logic              underrun,
    output logic              fmt
);

    localparam int BIT_W = $clog2(2 * SLOT_W);

    localparam logic [BIT_W-1:0]  R_START = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0]  P_LAST  = BIT_W'(DATA_W);
    localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

    tx_state_t state;
    tx_state_t state_nxt;
    logic      run;
    logic      run_nxt;

    logic              frame_start;
    logic              frame_end;
    logic              frame_start_nxt;
    logic              fall_tick_nxt;
    logic [BIT_W-1:0]  bit_cnt_nxt;

    logic                hold_full;
    logic                hold_full_nxt;
    logic [DATA_W-1:0]   hold_l;
    logic [DATA_W-1:0]   hold_r;
    logic [2*DATA_W-1:0] shifter;
    logic                accept;

    logic                in_right;
    logic [BIT_W-1:0]    pos;
    logic [DATA_W-1:0]   word;
    logic [DATA_W-1:0]   mask;
    logic                slot_bit;

    i2s_clk_div #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_div (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .run_nxt         (run_nxt),
        .bclk            (bclk),
        .lrck            (lrck),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .frame_start_nxt (frame_start_nxt),
        .fall_tick_nxt   (fall_tick_nxt),
        .bit_cnt_nxt     (bit_cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN:  if (frame_end && !enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign run     = (state == ST_RUN);
    assign run_nxt = (state_nxt == ST_RUN);

    assign s_ready = !hold_full;
    assign accept  = s_valid && !hold_full;

    // A frame-start load and an accept never collide on a full register:
    // accept needs it empty, so the load path only ever clears a full one.
    always_comb begin
        hold_full_nxt = hold_full;
        if (frame_start) hold_full_nxt = 1'b0;
        if (accept)      hold_full_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            shifter   <= '0;
            underrun  <= 1'b0;
        end else begin
            hold_full <= hold_full_nxt;
            if (accept) begin
                hold_l <= s_left;
                hold_r <= s_right;
            end
            if (frame_start) begin
                shifter <= hold_full ? {hold_l, hold_r} : '0;
            end
            // Registered one clk early so the pulse coincides with the
            // frame-start clk; the held state seen then is hold_full_nxt.
            underrun <= frame_start_nxt && !hold_full_nxt;
        end
    end

    // Bit for the slot position that becomes current on the next BCLK fall.
    // The shifter only reloads on frame start, which is never a fall clk,
    // so the current shifter contents are valid here.
    always_comb begin
        in_right = (bit_cnt_nxt >= R_START);
        pos      = in_right ? (bit_cnt_nxt - R_START) : bit_cnt_nxt;
        word     = in_right ? shifter[DATA_W-1:0] : shifter[2*DATA_W-1:DATA_W];
        mask     = MSB_ONE >> (pos - 1'b1);
        slot_bit = 1'b0;
        if ((pos != '0) && (pos <= P_LAST)) begin
            slot_bit = |(word & mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sdata <= 1'b0;
        end else if (!run_nxt) begin
            sdata <= 1'b0;
        end else if (fall_tick_nxt) begin
            sdata <= slot_bit;
        end
    end

    assign fmt = I2S_FMT_I2S;

endmodule
